// File: rtl/mac_send.sv
// mac_send: Ethernet transmit framer arbitrating between ARP and UDP clients.
// Adds preamble/SFD, MAC header, zero padding and CRC-32 FCS, then holds the IFG.
module mac_send #(
    parameter int MAX_PAYLOAD = 1502,
    parameter int MIN_PAYLOAD = 48,
    parameter int IFG_BYTES   = 12
) (
    input  logic        tx_clock,
    input  logic        reset_n,
    input  logic [47:0] local_mac,
    input  logic        arp_tx_request,
    input  logic        arp_tx_active,
    input  logic [7:0]  arp_tx_data,
    input  logic [47:0] arp_destination_mac,
    output logic        arp_tx_enable,
    input  logic        udp_tx_request,
    input  logic        udp_tx_active,
    input  logic [7:0]  udp_tx_data,
    input  logic [47:0] udp_destination_mac,
    output logic        udp_tx_enable,
    output logic [7:0]  phy_tx_data,
    output logic        phy_tx_en,
    output logic        busy,
    output logic        frame_err
);
    typedef enum logic [2:0] {
        IDLE, PREAMBLE, DEST, SRC, PAYLOAD, PAD, FCS, IFG
    } state_t;

    localparam logic [10:0] MAX_C = 11'(MAX_PAYLOAD);
    localparam logic [10:0] MIN_C = 11'(MIN_PAYLOAD);
    localparam logic [10:0] IFG_C = 11'(IFG_BYTES);

    state_t      state_q;
    logic [10:0] cnt_q;
    logic [31:0] crc_q;
    logic [47:0] dst_q;
    logic [47:0] src_q;
    logic        sel_q;
    logic [7:0]  data_q;
    logic        en_q;
    logic        busy_q;
    logic        ferr_q;
    logic        arp_en_q;
    logic        udp_en_q;

    logic        act_w;
    logic [7:0]  byte_w;
    logic [10:0] cnt_inc;
    logic [31:0] fcs_w;
    logic [7:0]  fcs_byte;

    function automatic logic [31:0] crc_next(input logic [31:0] c,
                                             input logic [7:0]  d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    assign act_w   = sel_q ? udp_tx_active : arp_tx_active;
    assign byte_w  = sel_q ? udp_tx_data : arp_tx_data;
    assign cnt_inc = cnt_q + 11'd1;
    assign fcs_w   = ~crc_q;

    always_comb begin
        fcs_byte = fcs_w[7:0];
        unique case (cnt_q[1:0])
            2'd0: fcs_byte = fcs_w[7:0];
            2'd1: fcs_byte = fcs_w[15:8];
            2'd2: fcs_byte = fcs_w[23:16];
            2'd3: fcs_byte = fcs_w[31:24];
        endcase
    end

    // Each state decides the byte registered onto the PHY at the coming edge.
    always_ff @(posedge tx_clock) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            crc_q    <= '1;
            dst_q    <= '0;
            src_q    <= '0;
            sel_q    <= 1'b0;
            data_q   <= '0;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            ferr_q   <= 1'b0;
            arp_en_q <= 1'b0;
            udp_en_q <= 1'b0;
        end else begin
            arp_en_q <= 1'b0;
            udp_en_q <= 1'b0;
            ferr_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    en_q   <= 1'b0;
                    data_q <= 8'h00;
                    if (arp_tx_request || udp_tx_request) begin
                        sel_q   <= ~arp_tx_request;
                        dst_q   <= arp_tx_request ? arp_destination_mac
                                                  : udp_destination_mac;
                        src_q   <= local_mac;
                        crc_q   <= '1;
                        en_q    <= 1'b1;
                        data_q  <= 8'h55;
                        busy_q  <= 1'b1;
                        cnt_q   <= 11'd1;
                        state_q <= PREAMBLE;
                    end
                end
                PREAMBLE: begin
                    data_q <= (cnt_q == 11'd7) ? 8'hD5 : 8'h55;
                    cnt_q  <= cnt_inc;
                    if (cnt_q == 11'd7) begin
                        cnt_q   <= '0;
                        state_q <= DEST;
                    end
                end
                DEST: begin
                    data_q <= dst_q[47:40];
                    crc_q  <= crc_next(crc_q, dst_q[47:40]);
                    dst_q  <= dst_q << 8;
                    cnt_q  <= cnt_inc;
                    if (cnt_q == 11'd5) begin
                        cnt_q   <= '0;
                        state_q <= SRC;
                    end
                end
                SRC: begin
                    data_q <= src_q[47:40];
                    crc_q  <= crc_next(crc_q, src_q[47:40]);
                    src_q  <= src_q << 8;
                    cnt_q  <= cnt_inc;
                    if (cnt_q == 11'd5) begin
                        cnt_q    <= '0;
                        arp_en_q <= ~sel_q;
                        udp_en_q <= sel_q;
                        state_q  <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (act_w) begin
                        data_q <= byte_w;
                        crc_q  <= crc_next(crc_q, byte_w);
                        cnt_q  <= cnt_inc;
                        if (cnt_inc == MAX_C) begin
                            ferr_q  <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= FCS;
                        end
                    end else if (cnt_q >= MIN_C) begin
                        // No padding needed: first FCS byte goes out now.
                        data_q  <= fcs_w[7:0];
                        cnt_q   <= 11'd1;
                        state_q <= FCS;
                    end else begin
                        data_q  <= 8'h00;
                        crc_q   <= crc_next(crc_q, 8'h00);
                        cnt_q   <= cnt_inc;
                        state_q <= PAD;
                        if (cnt_inc == MIN_C) begin
                            cnt_q   <= '0;
                            state_q <= FCS;
                        end
                    end
                end
                PAD: begin
                    data_q <= 8'h00;
                    crc_q  <= crc_next(crc_q, 8'h00);
                    cnt_q  <= cnt_inc;
                    if (cnt_inc == MIN_C) begin
                        cnt_q   <= '0;
                        state_q <= FCS;
                    end
                end
                FCS: begin
                    data_q <= fcs_byte;
                    cnt_q  <= cnt_inc;
                    if (cnt_q[1:0] == 2'd3) begin
                        cnt_q   <= '0;
                        state_q <= IFG;
                    end
                end
                IFG: begin
                    en_q   <= 1'b0;
                    data_q <= 8'h00;
                    cnt_q  <= cnt_inc;
                    if (cnt_q == IFG_C) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign phy_tx_data   = data_q;
    assign phy_tx_en     = en_q;
    assign busy          = busy_q;
    assign frame_err     = ferr_q;
    assign arp_tx_enable = arp_en_q;
    assign udp_tx_enable = udp_en_q;
endmodule

// File: tb/tb_mac_send.sv
// tb_mac_send: scoreboard bench for the mac_send Ethernet framer.
// Expected PHY bytes are queued from a CRC model, then checked per scenario.
module tb_mac_send;
    localparam int MAXP = 1502;
    localparam int MINP = 48;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [47:0] lmac;
    logic        arp_req, arp_act, arp_en;
    logic [7:0]  arp_dat;
    logic [47:0] arp_dst;
    logic        udp_req, udp_act, udp_en;
    logic [7:0]  udp_dat;
    logic [47:0] udp_dst;
    logic [7:0]  phy_data;
    logic        phy_en, busy, ferr;

    int tests = 0;
    int fails = 0;

    logic [7:0] pay_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int t_en, en_cnt, oth_en, t_first, t_last, t_done, ferr_cnt;

    always #5 clk = ~clk;

    mac_send dut (
        .tx_clock            (clk),
        .reset_n             (rst_n),
        .local_mac           (lmac),
        .arp_tx_request      (arp_req),
        .arp_tx_active       (arp_act),
        .arp_tx_data         (arp_dat),
        .arp_destination_mac (arp_dst),
        .arp_tx_enable       (arp_en),
        .udp_tx_request      (udp_req),
        .udp_tx_active       (udp_act),
        .udp_tx_data         (udp_dat),
        .udp_destination_mac (udp_dst),
        .udp_tx_enable       (udp_en),
        .phy_tx_data         (phy_data),
        .phy_tx_en           (phy_en),
        .busy                (busy),
        .frame_err           (ferr)
    );

    function automatic logic [31:0] crc_model(input logic [31:0] c,
                                              input logic [7:0]  b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    task automatic build_exp(input logic [47:0] dst, input int n);
        logic [31:0] c;
        logic [7:0]  b;
        int          np;
        exp_q.delete();
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < 12; i++) begin
            if (i < 6) b = 8'(dst >> (40 - 8 * i));
            else       b = 8'(lmac >> (40 - 8 * (i - 6)));
            exp_q.push_back(b);
            c = crc_model(c, b);
        end
        np = (n > MAXP) ? MAXP : n;
        for (int i = 0; i < np; i++) begin
            exp_q.push_back(pay_q[i]);
            c = crc_model(c, pay_q[i]);
        end
        for (int i = np; i < MINP; i++) begin
            exp_q.push_back(8'h00);
            c = crc_model(c, 8'h00);
        end
        c = ~c;
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(c >> (8 * i)));
    endtask

    task automatic rand_payload(input int n);
        pay_q.delete();
        for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
    endtask

    // Cycle 0 is the current slot; the request is sampled at its closing edge.
    task automatic run_frame(input bit cli, input int n);
        int sent;
        bit feed, seen;
        got_q.delete();
        t_en = -1; en_cnt = 0; oth_en = 0; t_first = -1;
        t_last = -1; t_done = -1; ferr_cnt = 0;
        sent = 0; feed = 0; seen = 0;
        if (cli) udp_req = 1'b1;
        else     arp_req = 1'b1;
        for (int c = 1; c <= 4000 && t_done < 0; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                if (cli) udp_req = 1'b0;
                else     arp_req = 1'b0;
            end
            if (cli ? udp_en : arp_en) begin
                en_cnt++;
                if (t_en < 0) t_en = c;
                feed = 1'b1;
            end
            if (cli ? arp_en : udp_en) oth_en++;
            if (phy_en) begin
                got_q.push_back(phy_data);
                if (t_first < 0) t_first = c;
                t_last = c;
            end
            if (ferr) ferr_cnt++;
            if (busy) seen = 1'b1;
            else if (seen) t_done = c;
            arp_act = 1'b0;
            udp_act = 1'b0;
            if (feed && sent < n) begin
                if (cli) begin udp_act = 1'b1; udp_dat = pay_q[sent]; end
                else     begin arp_act = 1'b1; arp_dat = pay_q[sent]; end
                sent++;
            end
        end
        arp_act = 1'b0;
        udp_act = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (phy_en !== 1'b0) begin
            fails++; $display("FAIL rst_phy_en got %b exp 0", phy_en);
        end
        tests++;
        if (phy_data !== 8'h00) begin
            fails++; $display("FAIL rst_phy_data got %h exp 00", phy_data);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL rst_busy got %b exp 0", busy);
        end
        tests++;
        if (ferr !== 1'b0) begin
            fails++; $display("FAIL rst_frame_err got %b exp 0", ferr);
        end
        tests++;
        if ({arp_en, udp_en} !== 2'b00) begin
            fails++; $display("FAIL rst_enables got %b exp 00", {arp_en, udp_en});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_arp();
        logic [7:0]  pl [30];
        logic [31:0] r;
        logic [7:0]  e, g;
        int          nbad, ngot;
        pl = '{8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04,
               8'h00, 8'h02, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
               8'hC0, 8'hA8, 8'h01, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33,
               8'h44, 8'h55, 8'hC0, 8'hA8, 8'h01, 8'h01};
        pay_q.delete();
        foreach (pl[i]) pay_q.push_back(pl[i]);
        arp_dst = 48'h0011_2233_4455;
        build_exp(arp_dst, 30);
        run_frame(1'b0, 30);
        tests++;
        if (t_en !== 20 || en_cnt !== 1) begin
            fails++; $display("FAIL arp_enable got cyc %0d cnt %0d exp cyc 20 cnt 1", t_en, en_cnt);
        end
        tests++;
        if (oth_en !== 0) begin
            fails++; $display("FAIL arp_udp_enable got %0d pulses exp 0", oth_en);
        end
        tests++;
        if (t_first !== 1 || t_last !== 72) begin
            fails++; $display("FAIL arp_en_window got %0d..%0d exp 1..72", t_first, t_last);
        end
        ngot = got_q.size();
        r = 32'hFFFF_FFFF;
        for (int i = 8; i < ngot; i++) r = crc_model(r, got_q[i]);
        tests++;
        if (r !== 32'hDEBB20E3) begin
            fails++; $display("FAIL arp_residue got %h exp DEBB20E3", r);
        end
        tests++;
        if (ngot !== exp_q.size()) begin
            fails++; $display("FAIL arp_len got %0d exp %0d", ngot, exp_q.size());
        end
        nbad = 0;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            if (g !== e) nbad++;
        end
        tests++;
        if (nbad !== 0) begin
            fails++; $display("FAIL arp_bytes got %0d bad bytes exp 0", nbad);
        end
        tests++;
        if (t_done !== 85) begin
            fails++; $display("FAIL arp_busy_low got %0d exp 85", t_done);
        end
    endtask

    task automatic test_priority();
        logic [7:0] e, g;
        int         nbad;
        arp_dst = 48'hFFFF_FFFF_FFFF;
        udp_dst = 48'h1A2B_3C4D_5E6F;
        rand_payload(20);
        build_exp(arp_dst, 20);
        udp_req = 1'b1;
        run_frame(1'b0, 20);
        tests++;
        if (t_en !== 20 || oth_en !== 0) begin
            fails++; $display("FAIL prio_arp_first got arp %0d udp %0d exp 20 0", t_en, oth_en);
        end
        nbad = (got_q.size() == exp_q.size()) ? 0 : 1;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            if (g !== e) nbad++;
        end
        tests++;
        if (nbad !== 0 || t_done !== 85) begin
            fails++; $display("FAIL prio_arp_frame got %0d bad done %0d exp 0 85", nbad, t_done);
        end
        rand_payload(60);
        build_exp(udp_dst, 60);
        run_frame(1'b1, 60);
        tests++;
        if (t_en !== 20 || t_first !== 1) begin
            fails++; $display("FAIL prio_udp_grant got en %0d first %0d exp 20 1", t_en, t_first);
        end
        nbad = (got_q.size() == exp_q.size()) ? 0 : 1;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            if (g !== e) nbad++;
        end
        tests++;
        if (nbad !== 0 || t_done !== 97) begin
            fails++; $display("FAIL prio_udp_frame got %0d bad done %0d exp 0 97", nbad, t_done);
        end
    endtask

    task automatic test_udp100();
        logic [7:0] e, g;
        int         nbad;
        udp_dst = 48'hA0B1_C2D3_E4F5;
        rand_payload(100);
        build_exp(udp_dst, 100);
        run_frame(1'b1, 100);
        tests++;
        if (got_q.size() !== 124 || t_last - t_first + 1 !== 124) begin
            fails++; $display("FAIL udp100_len got %0d span %0d exp 124", got_q.size(), t_last - t_first + 1);
        end
        tests++;
        if (t_en !== 20) begin
            fails++; $display("FAIL udp100_enable got %0d exp 20", t_en);
        end
        nbad = 0;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            if (g !== e) nbad++;
        end
        tests++;
        if (nbad !== 0) begin
            fails++; $display("FAIL udp100_bytes got %0d bad bytes exp 0", nbad);
        end
        tests++;
        if (t_done !== 137) begin
            fails++; $display("FAIL udp100_busy_low got %0d exp 137", t_done);
        end
    endtask

    task automatic test_trunc();
        logic [7:0] e, g;
        int         nbad;
        udp_dst = 48'h0203_0405_0607;
        rand_payload(1510);
        build_exp(udp_dst, 1510);
        run_frame(1'b1, 1510);
        tests++;
        if (ferr_cnt !== 1) begin
            fails++; $display("FAIL trunc_frame_err got %0d pulses exp 1", ferr_cnt);
        end
        tests++;
        if (got_q.size() !== 1526 || t_last !== 1526) begin
            fails++; $display("FAIL trunc_len got %0d last %0d exp 1526", got_q.size(), t_last);
        end
        nbad = 0;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            if (g !== e) nbad++;
        end
        tests++;
        if (nbad !== 0) begin
            fails++; $display("FAIL trunc_bytes got %0d bad bytes exp 0", nbad);
        end
        tests++;
        if (t_done !== 1539) begin
            fails++; $display("FAIL trunc_busy_low got %0d exp 1539", t_done);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] e, g;
        int         nbad;
        udp_dst = 48'h0A0B_0C0D_0E0F;
        rand_payload(40);
        udp_req = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        tests++;
        if (phy_en !== 1'b1) begin
            fails++; $display("FAIL rmid_in_frame got %b exp 1", phy_en);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (phy_en !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL rmid_drop got en %b busy %b exp 0 0", phy_en, busy);
        end
        rst_n = 1'b1;
        build_exp(udp_dst, 40);
        run_frame(1'b1, 40);
        tests++;
        if (t_first !== 1 || t_en !== 20) begin
            fails++; $display("FAIL rmid_regrant got first %0d en %0d exp 1 20", t_first, t_en);
        end
        nbad = (got_q.size() == exp_q.size()) ? 0 : 1;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            if (g !== e) nbad++;
        end
        tests++;
        if (nbad !== 0 || t_done !== 85) begin
            fails++; $display("FAIL rmid_frame got %0d bad done %0d exp 0 85", nbad, t_done);
        end
    endtask

    task automatic test_min48();
        logic [7:0] e, g;
        int         nbad;
        arp_dst = 48'h3C4D_5E6F_7081;
        rand_payload(48);
        build_exp(arp_dst, 48);
        run_frame(1'b0, 48);
        tests++;
        if (got_q.size() !== 72 || t_last !== 72) begin
            fails++; $display("FAIL min48_len got %0d last %0d exp 72", got_q.size(), t_last);
        end
        nbad = 0;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            if (g !== e) nbad++;
        end
        tests++;
        if (nbad !== 0) begin
            fails++; $display("FAIL min48_bytes got %0d bad bytes exp 0", nbad);
        end
        tests++;
        if (t_done !== 85 || ferr_cnt !== 0) begin
            fails++; $display("FAIL min48_end got done %0d ferr %0d exp 85 0", t_done, ferr_cnt);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        lmac    = 48'h0200_0000_0001;
        arp_req = 1'b0; arp_act = 1'b0; arp_dat = 8'h00; arp_dst = '0;
        udp_req = 1'b0; udp_act = 1'b0; udp_dat = 8'h00; udp_dst = '0;
        test_reset();
        test_arp();
        test_priority();
        test_udp100();
        test_trunc();
        test_reset_mid();
        test_min48();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
